// File: rtl/dpram_port_sequencer.sv
// Request-side sequencer for one port of a dual-port memory: registered port pins,
// read-latency tracking and a credit-protected response FIFO.
module dpram_port_sequencer #(
    parameter int WIDTH      = 12,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LAT     = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_req_valid,
    output logic                               o_req_ready,
    input  logic                               i_req_we,
    input  logic [ADDR_WIDTH-1:0]              i_req_addr,
    input  logic [WIDTH-1:0]                   i_req_wdata,
    output logic                               o_mem_en,
    output logic                               o_mem_we,
    output logic [ADDR_WIDTH-1:0]              o_mem_addr,
    output logic [WIDTH-1:0]                   o_mem_din,
    input  logic [WIDTH-1:0]                   i_mem_dout,
    output logic                               o_rsp_valid,
    input  logic                               i_rsp_ready,
    output logic [WIDTH-1:0]                   o_rsp_rdata,
    output logic [$clog2(RSP_DEPTH+1)-1:0]     o_rd_pending
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);

    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      din_q, din_d;
    logic [RD_LAT:0]       vld_pipe_q, vld_pipe_d;
    logic [WIDTH-1:0]      fifo_q [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [CW-1:0]         inflight;
    logic [CW-1:0]         pending;
    logic                  accept;
    logic                  rd_accept;
    logic                  push;
    logic                  pop;

    // Credits cover both queued and in-flight reads, so a returning word always has a slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            inflight = inflight + CW'(vld_pipe_q[i]);
        end
        pending = count_q + inflight;
    end

    assign o_req_ready  = !i_rst && (pending < CW'(RSP_DEPTH));
    assign accept       = i_req_valid && o_req_ready;
    assign rd_accept    = accept && !i_req_we;
    assign push         = vld_pipe_q[RD_LAT];
    assign o_rsp_valid  = (count_q != '0);
    assign pop          = o_rsp_valid && i_rsp_ready;
    assign o_rsp_rdata  = fifo_q[rd_ptr_q];
    assign o_rd_pending = pending;

    assign o_mem_en   = en_q;
    assign o_mem_we   = we_q;
    assign o_mem_addr = addr_q;
    assign o_mem_din  = din_q;

    always_comb begin
        en_d       = accept;
        we_d       = accept && i_req_we;
        addr_d     = addr_q;
        din_d      = din_q;
        if (accept) begin
            addr_d = i_req_addr;
            din_d  = i_req_we ? i_req_wdata : '0;
        end
        // Stage k high means the read accepted k edges ago; the last stage lines up with dout.
        vld_pipe_d = {vld_pipe_q[RD_LAT-1:0], rd_accept};
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            vld_pipe_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            en_q       <= en_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            vld_pipe_q <= vld_pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= i_mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_dpram_port_sequencer.sv
// Scoreboarded bench for dpram_port_sequencer: RD_LAT=1 instance for the main scenarios,
// RD_LAT=3 instance for the long-latency case, each with a behavioural memory.
module tb_dpram_port_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // RD_LAT=1 instance
    logic        req_valid, req_ready, req_we;
    logic [9:0]  req_addr;
    logic [11:0] req_wdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [11:0] mem_din, mem_dout;
    logic        rsp_valid, rsp_ready;
    logic [11:0] rsp_rdata;
    logic [2:0]  rd_pending;

    // RD_LAT=3 instance
    logic        req3_valid, req3_ready, req3_we;
    logic [9:0]  req3_addr;
    logic [11:0] req3_wdata;
    logic        mem3_en, mem3_we;
    logic [9:0]  mem3_addr;
    logic [11:0] mem3_din, mem3_dout;
    logic        rsp3_valid, rsp3_ready;
    logic [11:0] rsp3_rdata;
    logic [2:0]  rd3_pending;

    dpram_port_sequencer #(.WIDTH(12), .ADDR_WIDTH(10), .RD_LAT(1), .RSP_DEPTH(4)) u1 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
        .o_rd_pending(rd_pending)
    );

    dpram_port_sequencer #(.WIDTH(12), .ADDR_WIDTH(10), .RD_LAT(3), .RSP_DEPTH(4)) u3 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req3_valid), .o_req_ready(req3_ready), .i_req_we(req3_we),
        .i_req_addr(req3_addr), .i_req_wdata(req3_wdata),
        .o_mem_en(mem3_en), .o_mem_we(mem3_we), .o_mem_addr(mem3_addr), .o_mem_din(mem3_din),
        .i_mem_dout(mem3_dout),
        .o_rsp_valid(rsp3_valid), .i_rsp_ready(rsp3_ready), .o_rsp_rdata(rsp3_rdata),
        .o_rd_pending(rd3_pending)
    );

    // Memory models: word i preloaded with 0x100+i; RD_LAT=3 model has two extra output stages.
    logic [11:0] mem1 [1024];
    logic [11:0] mem3 [1024];
    logic        loaded = 1'b0;
    logic [11:0] r3_0, r3_1, r3_2;
    assign mem3_dout = r3_2;

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) begin
                mem1[i] <= 12'(12'h100 + i);
                mem3[i] <= 12'(12'h100 + i);
            end
            mem3[10'h3FF] <= 12'h123;
            loaded <= 1'b1;
        end else begin
            if (mem_en) begin
                if (mem_we) mem1[mem_addr] <= mem_din;
                else        mem_dout <= mem1[mem_addr];
            end
            if (mem3_en) begin
                if (mem3_we) mem3[mem3_addr] <= mem3_din;
                else         r3_0 <= mem3[mem3_addr];
            end
            r3_1 <= r3_0;
            r3_2 <= r3_1;
        end
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [11:0] expq [$];
    bit          track = 1'b0;
    int          max_pend = 0;
    bit          held = 1'b0;
    logic [11:0] held_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks payload stability and overflow.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=%0h required=none (t=%0t)", rsp_rdata, $time);
                end else begin
                    chk("rsp_data", {20'd0, rsp_rdata}, {20'd0, expq.pop_front()});
                end
            end
            if (held && rsp_valid) chk("rsp_stable", {20'd0, rsp_rdata}, {20'd0, held_data});
            held      = rsp_valid && !rsp_ready;
            held_data = rsp_rdata;
            if (u1.push && u1.count_q == 3'd4) begin
                checks++;
                failures++;
                $display("FAIL fifo_overflow actual=push_at_full required=no_push (t=%0t)", $time);
            end
            if (track && int'(rd_pending) > max_pend) max_pend = int'(rd_pending);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input bit we, input logic [9:0] a, input logic [11:0] d, input logic [11:0] exp);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_timeout actual=not_ready required=accept (t=%0t)", $time);
        end else if (!we) begin
            expq.push_back(exp);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 100 && (expq.size() != 0 || rsp_valid); k++) step();
        if (expq.size() != 0 || rsp_valid) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_left required=0", expq.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          c0;
        int          lat;
        logic [9:0]  a;
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
        req3_valid = 0; req3_we = 0; req3_addr = '0; req3_wdata = '0; rsp3_ready = 1;

        // Reset state
        repeat (3) step();
        chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
        chk("reset_en", {31'd0, mem_en}, 32'd0);
        chk("reset_we", {31'd0, mem_we}, 32'd0);
        chk("reset_addr", {22'd0, mem_addr}, 32'd0);
        chk("reset_din", {20'd0, mem_din}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rdata", {20'd0, rsp_rdata}, 32'd0);
        chk("reset_pending", {29'd0, rd_pending}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Write 0x005=0xABC then read it back
        rsp_ready = 1'b1;
        req(1'b1, 10'h005, 12'hABC, 12'h000);
        chk("wr_en", {31'd0, mem_en}, 32'd1);
        chk("wr_we", {31'd0, mem_we}, 32'd1);
        chk("wr_addr", {22'd0, mem_addr}, 32'h005);
        chk("wr_din", {20'd0, mem_din}, 32'hABC);
        req(1'b0, 10'h005, 12'h000, 12'hABC);
        chk("rd_en", {31'd0, mem_en}, 32'd1);
        chk("rd_we", {31'd0, mem_we}, 32'd0);
        chk("rd_din", {20'd0, mem_din}, 32'd0);
        chk("rd_valid_lat0", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("idle_en", {31'd0, mem_en}, 32'd0);
        chk("rd_valid_lat1", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("rd_valid_lat2", {31'd0, rsp_valid}, 32'd1);
        chk("rd_data_lat2", {20'd0, rsp_rdata}, 32'hABC);
        drain();

        // Credit exhaustion with consumer stalled
        rsp_ready = 1'b0;
        step();
        acc = 0;
        a = 10'h020;
        req_valid = 1'b1;
        req_we = 1'b0;
        for (int k = 0; k < 6; k++) begin
            req_addr = a;
            @(negedge clk);
            if (req_ready) begin
                expq.push_back(12'h100 + {2'b00, a});
                acc++;
                a = a + 10'd1;
            end
            step();
        end
        req_valid = 1'b0;
        chk("credit_accepts", acc, 32'd4);
        chk("credit_ready", {31'd0, req_ready}, 32'd0);
        chk("credit_pending", {29'd0, rd_pending}, 32'd4);
        repeat (3) step();
        chk("full_pending", {29'd0, rd_pending}, 32'd4);
        chk("full_head", {20'd0, rsp_rdata}, 32'h120);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("ready_before_pop", {31'd0, req_ready}, 32'd0);
        step();
        chk("ready_after_pop", {31'd0, req_ready}, 32'd1);
        chk("pending_after_pop", {29'd0, rd_pending}, 32'd3);
        drain();

        // Streaming reads 0..15
        max_pend = 0;
        track = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 16; k++) begin
            req(1'b0, 10'(k), 12'h000, (k == 5) ? 12'hABC : 12'(12'h100 + k));
        end
        chk("stream_cycles", cyc - c0, 32'd16);
        drain();
        track = 1'b0;
        chk("stream_max_pending", max_pend, 32'd3);

        // Reset with two reads in flight and one queued
        rsp_ready = 1'b0;
        req(1'b0, 10'h030, 12'h000, 12'h130);
        req(1'b0, 10'h031, 12'h000, 12'h131);
        req(1'b0, 10'h032, 12'h000, 12'h132);
        chk("pre_rst_pending", {29'd0, rd_pending}, 32'd3);
        chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("ready_during_rst", {31'd0, req_ready}, 32'd0);
        step();
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_pending", {29'd0, rd_pending}, 32'd0);
        chk("mid_rst_en", {31'd0, mem_en}, 32'd0);
        rst = 1'b0;
        expq.delete();
        #1;
        chk("ready_post_rst", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
        repeat (8) step();
        chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);

        // RD_LAT=3: read of 0x3FF
        req3_valid = 1'b1;
        req3_addr = 10'h3FF;
        @(negedge clk);
        chk("lat3_ready", {31'd0, req3_ready}, 32'd1);
        step();
        req3_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (rsp3_valid && lat == 0) begin
                lat = k;
                chk("lat3_data", {20'd0, rsp3_rdata}, 32'h123);
            end
        end
        chk("lat3_latency", lat, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
